switch_debouncer: RTL and testbench

//  Two-channel mechanical-switch conditioner that sits directly upstream of
//  the LED blinker and drives its switch-select inputs from raw board pins.
//  - Synchronises each raw pin into i_clock.
//  - Filters contact bounce with a per-channel stability counter.
//  - Outputs a clean level plus single-cycle rise/fall strobes per channel.

---
 rtl/switch_debouncer_pkg.sv | 39 +++
 rtl/switch_debouncer_channel.sv | 83 ++++++++
 rtl/switch_debouncer.sv | 57 +++++
 tb/tb_switch_debouncer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for the two-channel switch debouncer: timing defaults,
// the per-channel counter action, the registered output bundle and the
// helpers used for parameter sanity checks.
package switch_debouncer_pkg;

    // System clock the debouncer runs on, used to turn milliseconds into cycles.
    localparam int unsigned CLOCK_HZ    = 25000;
    // Bounce settling time of the board switches.
    localparam int unsigned DEBOUNCE_MS = 10;

    // Number of clock cycles in a given number of milliseconds.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLOCK_HZ / 1000) * ms;
    endfunction

    // 10 ms at 25 kHz -> 250 cycles.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = ms_to_cycles(DEBOUNCE_MS);
    localparam int unsigned CNT_W_DEFAULT           = 8;

    // What the stability counter does on the next enabled edge.
    typedef enum logic [1:0] {
        CNT_CLEAR, // input agrees with output, or filter disabled
        CNT_COUNT, // input disagrees, window not yet complete
        CNT_FLIP   // input disagreed for the whole window: accept it
    } cnt_action_e;

    // Registered per-channel outputs: clean level plus one-cycle edge strobes.
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } chan_out_t;

    // True when a counter of the given width can reach cycles-1 without wrapping.
    function automatic logic cnt_fits(input int unsigned cycles, input int unsigned width);
        return (longint'(1) << width) >= longint'(cycles);
    endfunction

endpackage

// File: rtl/switch_debouncer_channel.sv
// One debounce channel: 2-FF synchroniser, stability counter, clean level
// and single-cycle rise/fall strobes. All outputs come straight from flops.
module switch_debouncer_channel
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_enable,
    input  logic i_raw,
    output logic o_switch,
    output logic o_rise,
    output logic o_fall
);

    // Terminal count: the edge that sees this value with a disagreeing input
    // is the one that updates the output.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              sync_s1;
    logic              sync_s2;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    chan_out_t         out_q;
    chan_out_t         out_d;
    cnt_action_e       action;

    // Two-stage synchroniser for the asynchronous pin; runs even when the filter is disabled.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make s1 and s2 sample together, giving two real stages.
            sync_s1 <= i_raw;
            sync_s2 <= sync_s1;
        end
    end

    // Decide the counter action from the synchronised input and the current level.
    always_comb begin
        // NOTE: a default on every always_comb output keeps the logic free of inferred latches.
        action = CNT_CLEAR;
        if (i_enable && (sync_s2 != out_q.level)) begin
            action = (cnt_q == CNT_LAST) ? CNT_FLIP : CNT_COUNT;
        end
    end

    // Next counter value, level and strobes; strobes default low so they last one cycle.
    always_comb begin
        cnt_d = cnt_q;
        out_d = '{level: out_q.level, rise: 1'b0, fall: 1'b0};
        unique case (action)
            CNT_CLEAR: cnt_d = '0;
            CNT_COUNT: cnt_d = cnt_q + CNT_W'(1);
            CNT_FLIP: begin
                cnt_d      = '0;
                out_d.level = sync_s2;
                out_d.rise  = sync_s2;
                out_d.fall  = ~sync_s2;
            end
            default:   cnt_d = '0;
        endcase
    end

    // Counter, level and strobe registers; the counter tops out at CNT_LAST, so it never wraps.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign o_switch = out_q.level;
    assign o_rise   = out_q.rise;
    assign o_fall   = out_q.fall;

endmodule

// File: rtl/switch_debouncer.sv
// Two-channel mechanical switch conditioner feeding the LED blinker's
// switch-select inputs. Each raw pin gets its own independent debounce channel.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_enable,
    input  logic i_raw_1,
    input  logic i_raw_2,
    output logic o_switch_1,
    output logic o_switch_2,
    output logic o_rise_1,
    output logic o_fall_1,
    output logic o_rise_2,
    output logic o_fall_2
);

    // A one-cycle window cannot filter anything, and the counter must reach
    // DEBOUNCE_CYCLES-1 without wrapping.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("switch_debouncer: DEBOUNCE_CYCLES=%0d must be >= 2", DEBOUNCE_CYCLES);
    end
    if (!cnt_fits(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_width
        $error("switch_debouncer: CNT_W=%0d too narrow for DEBOUNCE_CYCLES=%0d", CNT_W, DEBOUNCE_CYCLES);
    end

    switch_debouncer_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_channel_1 (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_enable  (i_enable),
        .i_raw     (i_raw_1),
        .o_switch  (o_switch_1),
        .o_rise    (o_rise_1),
        .o_fall    (o_fall_1)
    );

    switch_debouncer_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_channel_2 (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_enable  (i_enable),
        .i_raw     (i_raw_2),
        .o_switch  (o_switch_2),
        .o_rise    (o_rise_2),
        .o_fall    (o_fall_2)
    );

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with an expected-event scoreboard.
// Stimulus pushes the edge number and values at which a strobe must appear;
// the monitor pops one entry whenever any strobe is seen and compares.
`timescale 1us/1ns
module tb_switch_debouncer;

    localparam int unsigned D = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;
    logic raw1  = 1'b1;
    logic raw2  = 1'b1;
    logic sw1, sw2, rise1, fall1, rise2, fall2;

    int total    = 0;
    int bad      = 0;
    int edge_cnt = 0;
    int b;

    // Expected strobe event: edge on which it appears, levels {sw1,sw2},
    // strobes {rise1,fall1,rise2,fall2}.
    typedef struct {
        int         edge_no;
        logic [1:0] sw;
        logic [3:0] stb;
    } exp_t;
    exp_t exp_q[$];

    switch_debouncer #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4)
    ) dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_enable   (en),
        .i_raw_1    (raw1),
        .i_raw_2    (raw2),
        .o_switch_1 (sw1),
        .o_switch_2 (sw2),
        .o_rise_1   (rise1),
        .o_fall_1   (fall1),
        .o_rise_2   (rise2),
        .o_fall_2   (fall2)
    );

    // 40 us period
    always #20 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t edge=%0d)", name, act, exp, $time, edge_cnt);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int edge_no, input logic [1:0] sw, input logic [3:0] stb);
        exp_t e;
        e.edge_no = edge_no;
        e.sw      = sw;
        e.stb     = stb;
        exp_q.push_back(e);
    endtask

    // Monitor: any strobe must match the oldest expected event.
    always @(negedge clk) begin
        logic [3:0] stb;
        exp_t       e;
        stb = {rise1, fall1, rise2, fall2};
        if (stb != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'(stb), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_edge", edge_cnt, e.edge_no);
                check("event_strobes", 32'(stb), 32'(e.stb));
                check("event_levels", 32'({sw1, sw2}), 32'(e.sw));
            end
        end
    end

    initial begin
        // 1. Reset with raw pins high; release and both channels rise together.
        rst_n = 1'b0; en = 1'b1; raw1 = 1'b1; raw2 = 1'b1;
        wait_neg(3);
        check("reset_outputs", 32'({sw1, sw2, rise1, fall1, rise2, fall2}), 32'd0);
        rst_n = 1'b1;
        b = edge_cnt;                 // first edge after release is b+1
        push(b + D + 2, 2'b11, 4'b1010);
        wait_neg(D + 1);
        check("reset_window_hold", 32'({sw1, sw2}), 32'd0);
        wait_neg(1);
        check("reset_window_done", 32'({sw1, sw2}), 32'b11);
        wait_neg(3);

        // 2. Clean steps on channel 1; channel 2 stays put.
        raw1 = 1'b0;
        b = edge_cnt;
        push(b + D + 2, 2'b01, 4'b0100);
        wait_neg(12);
        raw1 = 1'b1;
        b = edge_cnt;
        push(b + D + 2, 2'b11, 4'b1000);
        wait_neg(D + 1);
        check("step_before", 32'(sw1), 32'd0);
        wait_neg(1);
        check("step_after", 32'({sw1, sw2}), 32'b11);
        wait_neg(3);

        // 3. Bounce: drop channel 1, toggle every 3 cycles for 30 cycles, settle high.
        raw1 = 1'b0;
        b = edge_cnt;
        push(b + D + 2, 2'b01, 4'b0100);
        wait_neg(12);
        for (int i = 0; i < 10; i++) begin
            raw1 = (i % 2 == 0);
            wait_neg(3);
        end
        check("bounce_hold", 32'(sw1), 32'd0);
        raw1 = 1'b1;
        b = edge_cnt;
        push(b + D + 2, 2'b11, 4'b1000);
        wait_neg(D + 1);
        check("bounce_settle_before", 32'(sw1), 32'd0);
        wait_neg(1);
        check("bounce_settle_after", 32'(sw1), 32'd1);
        wait_neg(3);

        // 4. Glitch on channel 2: 7 low cycles ignored, 10 low cycles accepted.
        raw2 = 1'b0;
        wait_neg(D - 1);
        raw2 = 1'b1;
        wait_neg(12);
        check("glitch7_hold", 32'(sw2), 32'd1);
        raw2 = 1'b0;
        b = edge_cnt;
        push(b + D + 2, 2'b10, 4'b0001);
        wait_neg(12);
        check("glitch10_fall", 32'(sw2), 32'd0);

        // 5. Enable gating: drop enable with channel 2 counter at 5, hold 20, re-enable.
        raw2 = 1'b1;
        wait_neg(7);
        en = 1'b0;
        wait_neg(20);
        check("disabled_hold", 32'({sw1, sw2}), 32'b10);
        en = 1'b1;
        b = edge_cnt;
        push(b + D, 2'b11, 4'b0010);
        wait_neg(D - 1);
        check("reenable_before", 32'(sw2), 32'd0);
        wait_neg(1);
        check("reenable_after", 32'(sw2), 32'd1);
        wait_neg(3);

        // 6. Async reset mid-window between edges, then both channels step together.
        raw1 = 1'b0; raw2 = 1'b0;
        wait_neg(5);
        #5 rst_n = 1'b0;
        #1 check("async_reset", 32'({sw1, sw2, rise1, fall1, rise2, fall2}), 32'd0);
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(3);
        raw1 = 1'b1; raw2 = 1'b1;
        b = edge_cnt;
        push(b + D + 2, 2'b11, 4'b1010);
        wait_neg(12);
        check("both_step_levels", 32'({sw1, sw2}), 32'b11);

        wait_neg(5);
        check("events_outstanding", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
